// File: rtl/w_regfile_writeback_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : w_regfile_writeback_pkg
//  Description : Shared widths and W-stage result-select codes for write-back.
//  Revision    : 1.0  initial release
// ============================================================================
package w_regfile_writeback_pkg;

    localparam int DATA_W   = 32;
    localparam int ADDR_W   = 5;
    localparam int NREG     = 32;
    localparam int SEL_W    = 4;
    localparam int ZERO_REG = 0;

    localparam logic [SEL_W-1:0] SEL_ALU = 4'd0;
    localparam logic [SEL_W-1:0] SEL_MEM = 4'd1;
    localparam logic [SEL_W-1:0] SEL_PC8 = 4'd2;
    localparam logic [SEL_W-1:0] SEL_MD  = 4'd3;

endpackage
`default_nettype wire

// File: rtl/w_result_mux.sv
`default_nettype none
// ============================================================================
//  Module      : w_result_mux
//  Description : Combinational 4:1 selection of the W-stage result.
//  Revision    : 1.0  initial release
// ============================================================================
module w_result_mux
    import w_regfile_writeback_pkg::*;
#(
    parameter int DATA_W = w_regfile_writeback_pkg::DATA_W
) (
    input  logic [SEL_W-1:0]  i_sel,
    input  logic [DATA_W-1:0] i_alu_re,
    input  logic [DATA_W-1:0] i_load_data,
    input  logic [DATA_W-1:0] i_pc8,
    input  logic [DATA_W-1:0] i_md_data,
    output logic [DATA_W-1:0] o_wd
);

    // Unassigned select codes fall back to the ALU result.
    always_comb begin
        o_wd = i_alu_re;
        case (i_sel)
            SEL_ALU: o_wd = i_alu_re;
            SEL_MEM: o_wd = i_load_data;
            SEL_PC8: o_wd = i_pc8;
            SEL_MD:  o_wd = i_md_data;
            default: o_wd = i_alu_re;
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/w_regfile_writeback.sv
`default_nettype none
// ============================================================================
//  Module      : w_regfile_writeback
//  Description : W-stage result select, general register file and D-stage
//                read ports. Optional macro GRF_BYPASS_EN enables write-through
//                of the W result onto matching read ports.
//  Revision    : 1.0  initial release
// ============================================================================
module w_regfile_writeback
    import w_regfile_writeback_pkg::*;
#(
    parameter int DATA_W = w_regfile_writeback_pkg::DATA_W,
    parameter int ADDR_W = w_regfile_writeback_pkg::ADDR_W,
    parameter int NREG   = w_regfile_writeback_pkg::NREG
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              W_RegWrite,
    input  logic [SEL_W-1:0]  W_RegWriteSel,
    input  logic [ADDR_W-1:0] W_A3,
    input  logic [DATA_W-1:0] W_ALURe,
    input  logic [DATA_W-1:0] W_LoadData,
    input  logic [DATA_W-1:0] W_PC8,
    input  logic [DATA_W-1:0] W_MDData,
    input  logic [DATA_W-1:0] W_PC,
    input  logic [ADDR_W-1:0] D_A1,
    input  logic [ADDR_W-1:0] D_A2,
    output logic [DATA_W-1:0] D_RD1,
    output logic [DATA_W-1:0] D_RD2,
    output logic [DATA_W-1:0] W_WD,
    output logic              W_WE
);

    localparam logic [ADDR_W-1:0] c_zero_idx = ADDR_W'(ZERO_REG);

    logic [DATA_W-1:0] r_regs [1:NREG-1];
    logic [DATA_W-1:0] w_rd1_stored;
    logic [DATA_W-1:0] w_rd2_stored;
    logic              w_unused_pc;

    // W_PC only travels with the bundle for trace purposes.
    assign w_unused_pc = ^W_PC;

    w_result_mux #(
        .DATA_W      (DATA_W)
    ) u_result_mux (
        .i_sel       (W_RegWriteSel),
        .i_alu_re    (W_ALURe),
        .i_load_data (W_LoadData),
        .i_pc8       (W_PC8),
        .i_md_data   (W_MDData),
        .o_wd        (W_WD)
    );

    assign W_WE = W_RegWrite && (W_A3 != c_zero_idx);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 1; i < NREG; i++) begin
                r_regs[i] <= '0;
            end
        end else if (W_WE) begin
            r_regs[W_A3] <= W_WD;
        end
    end

    // Entry 0 has no storage; its reads are forced to zero here.
    always_comb begin
        w_rd1_stored = '0;
        w_rd2_stored = '0;
        if (D_A1 != c_zero_idx) begin
            w_rd1_stored = r_regs[D_A1];
        end
        if (D_A2 != c_zero_idx) begin
            w_rd2_stored = r_regs[D_A2];
        end
    end

`ifdef GRF_BYPASS_EN
    always_comb begin
        D_RD1 = '0;
        D_RD2 = '0;
        if (reset) begin
            D_RD1 = (W_WE && (D_A1 == W_A3)) ? W_WD : w_rd1_stored;
            D_RD2 = (W_WE && (D_A2 == W_A3)) ? W_WD : w_rd2_stored;
        end
    end
`else
    always_comb begin
        D_RD1 = '0;
        D_RD2 = '0;
        if (reset) begin
            D_RD1 = w_rd1_stored;
            D_RD2 = w_rd2_stored;
        end
    end
`endif

endmodule
`default_nettype wire
